// File: rtl/gpio_reg_arbiter.sv
// gpio_reg_arbiter: round-robin arbiter and IDLE/ISSUE/RESP access sequencer for the GPIO lite register port.
// Optional macro GPIO_ARB_LOCK_EN adds an ownership lock so one requester can do an atomic read-modify-write.
module gpio_reg_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 16
) (
   input  logic                        pclk,
   input  logic                        n_reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   input  logic [NUM_REQ-1:0]          req_lock,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        busy,
   output logic                        read,
   output logic                        write,
   output logic [ADDR_W-1:0]           addr,
   output logic [DATA_W-1:0]           wdata,
   input  logic [DATA_W-1:0]           rdata
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic                op_wr_q, op_wr_d;
   logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
   logic [DATA_W-1:0]   op_wdata_q, op_wdata_d;

   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

   logic                rr_found;
   logic [IDX_W-1:0]    rr_winner;
   logic [IDX_W-1:0]    cand;
   logic                grant_en;
   logic [IDX_W-1:0]    grant_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Explicit compare-and-wrap keeps the search correct for non-power-of-two NUM_REQ.
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = '0;
      cand      = last_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
         if (!rr_found && req[cand]) begin
            rr_found  = 1'b1;
            rr_winner = cand;
         end
      end
   end

`ifdef GPIO_ARB_LOCK_EN
   logic locked_q, locked_d;

   always_comb begin
      locked_d  = locked_q;
      grant_en  = 1'b0;
      grant_idx = rr_winner;
      if (state_q == S_IDLE) begin
         if (locked_q) begin
            if (req[owner_q]) begin
               grant_en  = 1'b1;
               grant_idx = owner_q;
               locked_d  = req_lock[owner_q];
            end else begin
               locked_d  = 1'b0;
            end
         end else if (rr_found) begin
            grant_en  = 1'b1;
            locked_d  = req_lock[rr_winner];
         end
      end
      // A held-low reset must keep gnt quiet even though it is decoded combinationally.
      grant_en = grant_en & n_reset;
   end

   always_ff @(posedge pclk or negedge n_reset) begin
      if (!n_reset) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= locked_d;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;

   always_comb begin
      grant_idx = rr_winner;
      // A held-low reset must keep gnt quiet even though it is decoded combinationally.
      grant_en  = (state_q == S_IDLE) && rr_found && n_reset;
   end
`endif

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      op_wr_d    = op_wr_q;
      op_addr_d  = op_addr_q;
      op_wdata_d = op_wdata_q;
      gnt        = '0;
      rsp_valid  = '0;
      rsp_rdata  = '0;
      read       = 1'b0;
      write      = 1'b0;
      addr       = '0;
      wdata      = '0;
      case (state_q)
         S_IDLE: begin
            if (grant_en) begin
               gnt        = ONE_HOT0 << grant_idx;
               op_wr_d    = req_write[grant_idx];
               op_addr_d  = addr_arr[grant_idx];
               op_wdata_d = wdata_arr[grant_idx];
               owner_d    = grant_idx;
               last_d     = grant_idx;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            addr    = op_addr_q;
            wdata   = op_wdata_q;
            write   = op_wr_q;
            read    = ~op_wr_q;
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = ONE_HOT0 << owner_q;
            rsp_rdata = op_wr_q ? '0 : rdata;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q != S_IDLE);

   always_ff @(posedge pclk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= S_IDLE;
         last_q     <= LAST_IDX;
         owner_q    <= '0;
         op_wr_q    <= 1'b0;
         op_addr_q  <= '0;
         op_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         op_wr_q    <= op_wr_d;
         op_addr_q  <= op_addr_d;
         op_wdata_q <= op_wdata_d;
      end
   end
endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Scoreboard bench for gpio_reg_arbiter: a register-file stand-in for the GPIO subunit, a queue-based
// reference model of grants/accesses, and a negedge monitor. Lock scenario built with GPIO_ARB_LOCK_EN.
module tb_gpio_reg_arbiter;
   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 16;

   logic            pclk = 1'b0;
   logic            n_reset;
   logic [N-1:0]    req, req_write, req_lock;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt, rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            busy, read, write;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   rdata;

   always #5 pclk = ~pclk;

   gpio_reg_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .pclk(pclk), .n_reset(n_reset), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .read(read), .write(write), .addr(addr), .wdata(wdata), .rdata(rdata)
   );

   // Register-file stand-in for the GPIO subunit; 0x20 behaves as clear-on-read INT_STATUS.
   logic [DW-1:0] sub_mem [64];
   logic          sub_clr, pin_edge;
   always @(posedge pclk) begin
      rdata <= '0;
      if (sub_clr) begin
         for (int i = 0; i < 64; i++) sub_mem[i] <= '0;
      end else begin
         if (read) begin
            rdata <= sub_mem[addr];
            if (addr == 6'h20) sub_mem[addr] <= '0;
         end
         if (write) sub_mem[addr] <= wdata;
         if (pin_edge) sub_mem[6'h20] <= sub_mem[6'h20] | 16'h0001;
      end
   end

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      int            idx;
      bit            wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] rd;
   } op_t;

   op_t gnt_q[$], strb_q[$], rsp_q[$];
   int  checks = 0;
   int  errors = 0;

   function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Reference model state
   bit [N-1:0]    pend;
   bit [N-1:0]    p_wr, p_lock;
   logic [AW-1:0] p_addr [N];
   logic [DW-1:0] p_data [N];
   logic [DW-1:0] ref_mem [64];
   int            m_last, m_phase, m_owner;
   bit            m_locked;
   op_t           m_cur;

   function automatic int rr_pick();
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_last + k) % N;
         if (pend[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_last   = N - 1;
      m_phase  = 0;
      m_locked = 0;
      m_owner  = 0;
      gnt_q.delete();
      strb_q.delete();
      rsp_q.delete();
   endtask

   task automatic model_eval();
      int w;
      case (m_phase)
         0: begin
            w = -1;
`ifdef GPIO_ARB_LOCK_EN
            if (m_locked) begin
               if (pend[m_owner]) w = m_owner;
               else m_locked = 0;
            end else begin
               w = rr_pick();
            end
            if (w >= 0) begin
               m_locked = p_lock[w];
               m_owner  = w;
            end
`else
            w = rr_pick();
`endif
            if (w >= 0) begin
               m_cur = '{cyc: cyc, idx: w, wr: p_wr[w], a: p_addr[w], d: p_data[w], rd: '0};
               gnt_q.push_back(m_cur);
               strb_q.push_back(m_cur);
               pend[w] = 0;
               m_last  = w;
               m_phase = 1;
            end
         end
         1: begin
            if (m_cur.wr) begin
               m_cur.rd = '0;
               ref_mem[m_cur.a] = m_cur.d;
            end else begin
               m_cur.rd = ref_mem[m_cur.a];
               if (m_cur.a == 6'h20) ref_mem[m_cur.a] = '0;
            end
            rsp_q.push_back(m_cur);
            m_phase = 2;
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic new_req(input int i, input bit wr, input int a, input int d, input bit lk);
      pend[i]   = 1;
      p_wr[i]   = wr;
      p_addr[i] = AW'(a);
      p_data[i] = DW'(d);
      p_lock[i] = lk;
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
      pin_edge = 0;
   endtask

   // Drive this cycle's inputs; idle requesters get junk operands so a wrong slot select shows up.
   task automatic apply_eval();
      for (int i = 0; i < N; i++) begin
         if (!pend[i]) begin
            p_wr[i]   = 1'($urandom);
            p_addr[i] = AW'($urandom);
            p_data[i] = DW'($urandom);
            p_lock[i] = 1'($urandom);
         end
         req[i]                  = pend[i];
         req_write[i]            = p_wr[i];
         req_lock[i]             = p_lock[i];
         req_addr[i*AW +: AW]    = p_addr[i];
         req_wdata[i*DW +: DW]   = p_data[i];
      end
      if (n_reset) model_eval();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((m_phase != 0 || pend != 0) && n < max_cyc) begin
         tick();
         apply_eval();
         n++;
      end
      if (n >= max_cyc) chk(1'b0, "drain_timeout", 64'(n), 64'(max_cyc));
      repeat (3) begin
         tick();
         apply_eval();
      end
   endtask

   task automatic do_one(input int i, input bit wr, input int a, input int d);
      new_req(i, wr, a, d, 1'b0);
      drain(40);
   endtask

   // Monitor: pops expectations only when the DUT presents gnt / strobe / response.
   int busy_from = -1, busy_to = -2;
   initial begin
      op_t e;
      logic [N-1:0] oh;
      forever begin
         @(negedge pclk);
         if (n_reset !== 1'b1) begin
            chk({gnt, rsp_valid, rsp_rdata, busy, read, write, addr, wdata} == '0, "reset_outputs",
                64'({gnt, rsp_valid, rsp_rdata, busy, read, write, addr, wdata}), 64'd0);
            busy_from = -1;
            busy_to   = -2;
            continue;
         end
         if (gnt != '0) begin
            if (gnt_q.size() == 0) begin
               chk(1'b0, "spurious_gnt", 64'(gnt), 64'd0);
            end else begin
               e  = gnt_q.pop_front();
               oh = N'(1) << e.idx;
               chk(gnt == oh, "gnt_onehot", 64'(gnt), 64'(oh));
               chk(cyc == e.cyc, "gnt_cycle", 64'(cyc), 64'(e.cyc));
               chk(busy == 1'b0, "busy_at_gnt", 64'(busy), 64'd0);
               busy_from = cyc + 1;
               busy_to   = cyc + 2;
            end
         end else if (gnt_q.size() != 0 && gnt_q[0].cyc <= cyc) begin
            e = gnt_q.pop_front();
            chk(1'b0, "missing_gnt", 64'd0, 64'(N'(1) << e.idx));
         end
         if (read || write) begin
            if (strb_q.size() == 0) begin
               chk(1'b0, "spurious_strobe", 64'({read, write}), 64'd0);
            end else begin
               e = strb_q.pop_front();
               chk({write, read} == {e.wr, ~e.wr}, "strobe_kind", 64'({write, read}), 64'({e.wr, ~e.wr}));
               chk(addr == e.a, "strobe_addr", 64'(addr), 64'(e.a));
               chk(wdata == e.d, "strobe_wdata", 64'(wdata), 64'(e.d));
               chk(cyc == e.cyc + 1, "strobe_cycle", 64'(cyc), 64'(e.cyc + 1));
            end
         end else begin
            chk(addr == '0 && wdata == '0, "idle_bus", 64'({addr, wdata}), 64'd0);
            if (strb_q.size() != 0 && strb_q[0].cyc + 1 <= cyc) begin
               e = strb_q.pop_front();
               chk(1'b0, "missing_strobe", 64'd0, 64'(e.a));
            end
         end
         if (rsp_valid != '0) begin
            if (rsp_q.size() == 0) begin
               chk(1'b0, "spurious_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               e  = rsp_q.pop_front();
               oh = N'(1) << e.idx;
               chk(rsp_valid == oh, "rsp_onehot", 64'(rsp_valid), 64'(oh));
               chk(rsp_rdata == e.rd, "rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
               chk(cyc == e.cyc + 2, "rsp_cycle", 64'(cyc), 64'(e.cyc + 2));
               $display("txn req%0d %s addr=%02h wdata=%04h rdata=%04h gnt_cyc=%0d",
                        e.idx, e.wr ? "WR" : "RD", e.a, e.d, rsp_rdata, e.cyc);
            end
         end else if (rsp_q.size() != 0 && rsp_q[0].cyc + 2 <= cyc) begin
            e = rsp_q.pop_front();
            chk(1'b0, "missing_rsp", 64'd0, 64'(e.rd));
         end
         chk(busy == (cyc >= busy_from && cyc <= busy_to), "busy", 64'(busy),
             64'(cyc >= busy_from && cyc <= busy_to));
      end
   end

   initial begin
      n_reset  = 1'b0;
      sub_clr  = 1'b1;
      pin_edge = 1'b0;
      pend     = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      model_reset();
      // Fairness: every requester holds a request straight out of reset.
      for (int i = 0; i < N; i++) new_req(i, 1'($urandom), 6'($urandom_range(0, 31)), int'($urandom), 1'b0);
      repeat (3) begin
         tick();
         apply_eval();
      end
      tick();
      n_reset = 1'b1;
      sub_clr = 1'b0;
      apply_eval();
      for (int c = 0; c < 30; c++) begin
         tick();
         for (int i = 0; i < N; i++)
            if (!pend[i]) new_req(i, 1'($urandom), 6'($urandom_range(0, 31)), int'($urandom), 1'b0);
         apply_eval();
      end
      drain(40);

      // Directed single write, read-back, and read path
      do_one(1, 1'b1, 6'h0C, 16'h00A5);
      do_one(0, 1'b0, 6'h0C, 0);
      do_one(3, 1'b1, 6'h04, 16'h00F0);
      do_one(0, 1'b0, 6'h04, 0);

      // Interrupt status: one pin edge, then two reads from requester 2
      tick();
      pin_edge = 1'b1;
      ref_mem[6'h20] = ref_mem[6'h20] | 16'h0001;
      apply_eval();
      tick();
      apply_eval();
      do_one(2, 1'b0, 6'h20, 0);
      do_one(2, 1'b0, 6'h20, 0);

      // Randomized traffic with withdrawals
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 99) < 35)
                  new_req(i, 1'($urandom), int'($urandom_range(0, 63)), int'($urandom),
                          $urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 99) < 4) begin
               pend[i] = 0;
            end
         end
         apply_eval();
      end
      drain(60);

      // Reset during the ISSUE cycle of a write to 0x08
      new_req(2, 1'b1, 6'h08, 16'h1234, 1'b0);
      begin
         int n;
         n = 0;
         while (m_phase != 1 && n < 20) begin
            tick();
            apply_eval();
            n++;
         end
         if (n >= 20) chk(1'b0, "grant_timeout", 64'(n), 64'd20);
      end
      tick();
      n_reset = 1'b0;
      model_reset();
      #1;
      chk({read, write, addr, wdata, busy} == '0, "abort_strobe", 64'({read, write, addr, wdata, busy}), 64'd0);
      new_req(0, 1'b0, 6'h08, 0, 1'b0);
      new_req(1, 1'b0, 6'h0C, 0, 1'b0);
      new_req(2, 1'b1, 6'h08, 16'h1234, 1'b0);
      apply_eval();
      repeat (2) begin
         tick();
         apply_eval();
      end
      tick();
      n_reset = 1'b1;
      apply_eval();
      drain(40);

`ifdef GPIO_ARB_LOCK_EN
      // Locked read by requester 3 keeps the port for its follow-up write despite 0 and 1 waiting.
      do_one(2, 1'b0, 6'h00, 0);
      tick();
      new_req(0, 1'b0, 6'h04, 0, 1'b0);
      new_req(1, 1'b0, 6'h08, 0, 1'b0);
      new_req(3, 1'b0, 6'h0C, 0, 1'b1);
      apply_eval();
      tick();
      new_req(3, 1'b1, 6'h0C, 16'h5A5A, 1'b0);
      apply_eval();
      drain(40);
`endif

      chk(gnt_q.size() + strb_q.size() + rsp_q.size() == 0, "queues_empty",
          64'(gnt_q.size() + strb_q.size() + rsp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
